tico_cdc_hs_tx: RTL and testbench
=================================

Name: tico_cdc_hs_tx

Overview:
- Source-side controller for a 4-phase req/ack bus synchronizer.
- Accepts a DW-bit word from local logic with a valid/ready handshake and holds it stable on data_o.
- Sequences req_o against an ack_i that arrives asynchronously from the destination clock domain.
- Resynchronizes ack_i internally through a 2-flop ASYNC_REG synchronizer, and flags stalled transfers with a watchdog counter.

Parameters:
- DW, 32, width of the transferred word.
- TIMEOUT_CYCLES, 1024, cycles allowed in REQ or REL before err_o sets; 0 disables the watchdog.

Ports:
- clk  in  1  source-domain clock.
- rst_n  in  1  asynchronous active-low reset.
- src_valid_i  in  1  local word valid.
- src_ready_o  out  1  controller can accept a word.
- src_data_i  in  DW  local word.
- req_o  out  1  4-phase request to destination domain (registered, glitch-free).
- data_o  out  DW  captured word; stable whenever req_o=1 and until the next accept.
- ack_i  in  1  4-phase acknowledge from destination domain (asynchronous).
- busy_o  out  1  transfer in progress (state != IDLE).
- done_o  out  1  one-cycle pulse: 4-phase cycle complete.
- err_clr_i  in  1  clears err_o.
- err_o  out  1  sticky watchdog error.

Behaviour:
- Reset values (async assert, sync release via rst_n): state=IDLE, req_o=0, data_o=0, done_o=0, err_o=0, counter=0, both sync flops=0. src_ready_o=1 and busy_o=0 follow from IDLE.
- ack_s is ack_i after 2 clk flops, so it lags ack_i by 2 edges. All FSM decisions use ack_s only.
- FSM states are IDLE, REQ, REL.
  - IDLE: src_ready_o=1.
    - On src_valid_i & src_ready_o at edge N: data_o<=src_data_i, req_o<=1, state<=REQ.
    - If ack_s=1 in IDLE (stale ack), accept is blocked: src_ready_o=0 until ack_s=0.
  - REQ: on ack_s=1, req_o<=0 and state<=REL.
  - REL: on ack_s=0, state<=IDLE and done_o<=1 for exactly one cycle.
- src_ready_o = (state==IDLE) & ~ack_s. It is combinational from registered state and sync flop, with no path from src_valid_i.
- Minimum back-to-back spacing:
  - Accept at edge N; ack_i rising just after N+1 gives ack_s=1 at N+3, req_o=0 after N+4.
  - Earliest next accept: 2 edges after ack_s falls.
- data_o changes only on accept; never while busy_o=1.
- Watchdog:
  - Counter clears on every state transition and increments each cycle in REQ or REL, saturating at TIMEOUT_CYCLES.
  - When count == TIMEOUT_CYCLES-1 and no transition occurs, err_o<=1.
  - The FSM keeps waiting; it never aborts mid-handshake, because aborting would break the 4-phase protocol.
  - Counter width is clog2(TIMEOUT_CYCLES+1).
- err_clr_i clears err_o the next edge. If clear and set occur in the same cycle, set wins.
- If src_valid_i is asserted while busy, no capture occurs and the word must be held by the source (standard valid/ready).
- Reset mid-transfer drops req_o to 0 immediately (async). The destination must tolerate an abandoned request; this is documented system-level.

Test Plan:
- Single transfer: reset; src_valid_i=1, src_data_i=0xDEADBEEF; destination model acks 1 cycle after seeing req_o.
  -> data_o=0xDEADBEEF from accept edge; req_o high 1 cycle after accept; req_o falls 3 edges after ack_i rises; one done_o pulse; src_ready_o returns 1.
- Back-to-back: 4 words 0x1, 0x2, 0x3, 0x4 with src_valid_i held high.
  -> Exactly 4 done_o pulses and 4 rising edges of req_o, in order.
  -> data_o never changes while req_o=1 or busy_o=1.
  -> src_ready_o=0 throughout each transfer.
- Stale ack: hold ack_i=1 through reset release.
  -> src_ready_o=0 until 2 edges after ack_i=0; no req_o rise before that.
- Watchdog: TIMEOUT_CYCLES=16; ack_i never rises.
  -> err_o rises 16 cycles after entering REQ; req_o stays 1.
  -> Late ack then completes normally with done_o pulse; err_o stays 1 until err_clr_i.
- Simultaneous set/clear: pulse err_clr_i in the same cycle the watchdog fires.
  -> err_o=1.
- Reset mid-operation: assert rst_n=0 while in REQ.
  -> req_o, data_o and busy_o go to 0 immediately (before next clk edge); src_ready_o=1 two edges after release once ack_i=0.

Source files
------------

// File: rtl/tico_cdc_hs_tx.sv
// Source side of a 4-phase req/ack bus synchronizer: captures a word, drives req_o
// against a resynchronized ack, and watches for stalled handshakes.
module tico_cdc_hs_tx #(
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          src_valid_i,
  output logic          src_ready_o,
  input  logic [DW-1:0] src_data_i,
  output logic          req_o,
  output logic [DW-1:0] data_o,
  input  logic          ack_i,
  output logic          busy_o,
  output logic          done_o,
  input  logic          err_clr_i,
  output logic          err_o
);

  localparam int unsigned CW         = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned FIRE_VAL   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_FIRE = CW'(FIRE_VAL);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_REL  = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  (* ASYNC_REG = "TRUE" *) logic r_ack_meta;
  (* ASYNC_REG = "TRUE" *) logic r_ack_s;
  logic            r_req, w_req_nxt;
  logic [DW-1:0]   r_data, w_data_nxt;
  logic            r_done, w_done_nxt;
  logic            r_err, w_err_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_ready;
  logic            w_move;
  logic            w_fire;

  // Two-flop resynchronizer for the destination-domain acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_meta <= 1'b0;
      r_ack_s    <= 1'b0;
    end else begin
      r_ack_meta <= ack_i;
      r_ack_s    <= r_ack_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A stale ack still high from a previous cycle blocks the next accept
  assign w_ready = (r_state == S_IDLE) && !r_ack_s;

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    w_move      = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_fire      = 1'b0;
    w_err_nxt   = r_err;

    case (r_state)
      S_IDLE: begin
        if (src_valid_i && w_ready) begin
          w_data_nxt  = src_data_i;
          w_req_nxt   = 1'b1;
          w_state_nxt = S_REQ;
          w_move      = 1'b1;
        end
      end
      S_REQ: begin
        if (r_ack_s) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = S_REL;
          w_move      = 1'b1;
        end
      end
      S_REL: begin
        if (!r_ack_s) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
          w_move      = 1'b1;
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase

    // Watchdog only flags the stall; the handshake itself is never aborted
    if (TIMEOUT_CYCLES != 0) begin
      if (w_move) begin
        w_cnt_nxt = '0;
      end else if ((r_state != S_IDLE) && (r_cnt != CNT_MAX)) begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
      w_fire = (r_state != S_IDLE) && !w_move && (r_cnt == CNT_FIRE);
    end

    if (w_fire) begin
      w_err_nxt = 1'b1;
    end else if (err_clr_i) begin
      w_err_nxt = 1'b0;
    end
  end

  assign src_ready_o = w_ready;
  assign busy_o      = (r_state != S_IDLE);
  assign req_o       = r_req;
  assign data_o      = r_data;
  assign done_o      = r_done;
  assign err_o       = r_err;

endmodule

// File: tb/tb_tico_cdc_hs_tx.sv
// Bench for tico_cdc_hs_tx: vector table, directed corner sequences and random traffic
// checked against a transaction-level handshake model.
module tb_tico_cdc_hs_tx;

  localparam int unsigned T = 16;

  logic        clk;
  logic        rst_n;
  logic        src_valid;
  logic        src_ready;
  logic [31:0] src_data;
  logic        req;
  logic [31:0] data;
  logic        ack;
  logic        busy;
  logic        done;
  logic        err_clr;
  logic        err;

  int errors;
  int checks;

  tico_cdc_hs_tx #(.DW(32), .TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_valid_i (src_valid),
    .src_ready_o (src_ready),
    .src_data_i  (src_data),
    .req_o       (req),
    .data_o      (data),
    .ack_i       (ack),
    .busy_o      (busy),
    .done_o      (done),
    .err_clr_i   (err_clr),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: ack as seen by the controller is ack_i two samples late
  logic        m_req, m_busy, m_done, m_err;
  logic [31:0] m_data;
  int          m_wait;
  logic [1:0]  m_dly;

  task automatic model_reset();
    m_req = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
    m_data = '0; m_wait = 0; m_dly = 2'b00;
  endtask

  task automatic model_step();
    logic s, rdy, acc, fin_req, fin_rel, moved, fire;
    s       = m_dly[1];
    rdy     = !m_busy && !s;
    acc     = src_valid && rdy;
    fin_req = m_busy && m_req && s;
    fin_rel = m_busy && !m_req && !s;
    moved   = acc || fin_req || fin_rel;
    fire    = m_busy && !moved && (m_wait == int'(T) - 1);
    if (fire) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    if (moved) m_wait = 0;
    else if (m_busy && m_wait < int'(T)) m_wait = m_wait + 1;
    m_done = fin_rel;
    if (acc) begin m_data = src_data; m_req = 1'b1; m_busy = 1'b1; end
    if (fin_req) m_req = 1'b0;
    if (fin_rel) m_busy = 1'b0;
    m_dly = {m_dly[0], ack};
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("ready", 32'(src_ready), 32'(!m_busy && !m_dly[1]));
    chk("req",   32'(req),  32'(m_req));
    chk("busy",  32'(busy), 32'(m_busy));
    chk("done",  32'(done), 32'(m_done));
    chk("err",   32'(err),  32'(m_err));
    chk("data",  data, m_data);
  endtask

  // Destination: follow req_o with a random per-cycle chance of 1/odds
  task automatic dest_step(input int unsigned odds);
    if (req !== ack && $urandom_range(odds - 1, 0) == 0) ack = req;
  endtask

  task automatic do_reset(input logic a);
    rst_n = 1'b0; src_valid = 1'b0; err_clr = 1'b0; src_data = '0; ack = a;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   32'(req),  32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_err",   32'(err),  32'd0);
    chk("rst_ready", 32'(src_ready), 32'd1);
    chk("rst_data",  data, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    src_valid = 1'b0;
    for (int c = 0; c < 40 && busy; c++) begin
      dest_step(1);
      cycle();
    end
    if (ack) begin
      ack = 1'b0;
      cycle(); cycle();
    end
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        a;
    logic        ex_rdy;
    logic        ex_req;
    logic        ex_busy;
    logic        ex_done;
    logic [31:0] ex_data;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int nd, nr, w;
    logic prev_req, prev_busy, acc, got;
    logic [31:0] prev_data;

    errors = 0; checks = 0;
    tbl[0] = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[1] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[4] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[5] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[6] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[7] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    tbl[8] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF};

    // Single transfer, cycle by cycle
    do_reset(1'b0);
    for (int i = 0; i < 9; i++) begin
      src_valid = tbl[i].v; src_data = tbl[i].d; ack = tbl[i].a;
      cycle();
      chk("tbl_ready", 32'(src_ready), 32'(tbl[i].ex_rdy));
      chk("tbl_req",   32'(req),  32'(tbl[i].ex_req));
      chk("tbl_busy",  32'(busy), 32'(tbl[i].ex_busy));
      chk("tbl_done",  32'(done), 32'(tbl[i].ex_done));
      chk("tbl_data",  data, tbl[i].ex_data);
    end

    // Back-to-back words with valid held high
    do_reset(1'b0);
    nd = 0; nr = 0; w = 0;
    src_valid = 1'b1; src_data = 32'd1;
    for (int c = 0; c < 200 && nd < 4; c++) begin
      dest_step(1);
      prev_req = req; prev_busy = busy; prev_data = data;
      cycle();
      if (!prev_req && req) begin
        nr++; w++;
        src_data = 32'(w + 1);
        if (w >= 4) src_valid = 1'b0;
      end
      if (prev_busy && busy) chk("b2b_hold", data, prev_data);
      if (done) begin
        nd++;
        chk("b2b_done_order", data, 32'(nd));
      end
    end
    chk("b2b_done_count", 32'(nd), 32'd4);
    chk("b2b_req_rises",  32'(nr), 32'd4);
    drain();

    // Stale ack held through reset release
    do_reset(1'b1);
    cycle(); cycle();
    chk("stale_ready", 32'(src_ready), 32'd0);
    src_valid = 1'b1; src_data = 32'h77;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("stale_no_req", 32'(req), 32'd0);
    end
    ack = 1'b0;
    cycle();
    chk("stale_ready_e1", 32'(src_ready), 32'd0);
    cycle();
    chk("stale_ready_e2", 32'(src_ready), 32'd1);
    chk("stale_req_e2",   32'(req), 32'd0);
    cycle();
    chk("stale_accept_req",  32'(req), 32'd1);
    chk("stale_accept_data", data, 32'h77);
    drain();

    // Watchdog with a late ack
    do_reset(1'b0);
    src_valid = 1'b1; src_data = 32'hA5A5A5A5;
    cycle();
    src_valid = 1'b0;
    for (int k = 1; k <= int'(T); k++) begin
      cycle();
      if (k == int'(T) - 1) chk("wd_err_early", 32'(err), 32'd0);
    end
    chk("wd_err_set", 32'(err), 32'd1);
    chk("wd_req_held", 32'(req), 32'd1);
    ack = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      dest_step(1);
      cycle();
      if (done) got = 1'b1;
    end
    chk("wd_late_done", 32'(got), 32'd1);
    chk("wd_err_sticky", 32'(err), 32'd1);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    chk("wd_err_cleared", 32'(err), 32'd0);

    // Clear and set in the same cycle: set wins
    src_valid = 1'b1; src_data = 32'h5A;
    cycle();
    src_valid = 1'b0;
    repeat (int'(T) - 1) cycle();
    chk("sw_err_before", 32'(err), 32'd0);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    chk("sw_set_wins", 32'(err), 32'd1);
    cycle();
    chk("sw_err_holds", 32'(err), 32'd1);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    chk("sw_err_clr", 32'(err), 32'd0);
    drain();

    // Reset in the middle of a request
    src_valid = 1'b1; src_data = 32'h1234;
    cycle();
    src_valid = 1'b0;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req",  32'(req),  32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data", data, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(); cycle();
    chk("mid_rst_ready", 32'(src_ready), 32'd1);

    // Random traffic against the model
    do_reset(1'b0);
    for (int c = 0; c < 3000; c++) begin
      dest_step(4);
      err_clr = ($urandom_range(15, 0) == 0);
      acc = src_valid && src_ready;
      cycle();
      if (acc || !src_valid) begin
        src_valid = 1'($urandom_range(1, 0));
        src_data  = $urandom;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
